// File: rtl/polilock_pkg.sv
// Shared definitions for the Polilock password loader: loader state codes,
// special byte values and the bit-period helper used by the UART receiver.
package polilock_pkg;

   // Loader state codes; these values also appear on db_estado.
   localparam logic [3:0] S_OCIOSO   = 4'd0;
   localparam logic [3:0] S_ESPERA   = 4'd1;
   localparam logic [3:0] S_GRAVA    = 4'd2;
   localparam logic [3:0] S_PREENCHE = 4'd3;
   localparam logic [3:0] S_FIM      = 4'd4;
   localparam logic [3:0] S_ERRO     = 4'd5;

   // A line feed ends the password early; the remaining addresses get FILL_BYTE.
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] FILL_BYTE = 8'h00;

   // Clocks per serial bit (integer division, as the line timing assumes).
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a two-flop input synchronizer. Emits a one-cycle
// byte_ok (with the byte on dado) or byte_err pulse at the stop-bit sample.
module uart_rx_8n1
   import polilock_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_ok,
   output logic       byte_err,
   output logic [7:0] dado
);

   // CLKS_BIT must be at least 4 so the half-bit start recheck is meaningful.
   localparam int CLKS_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int CNT_W    = $clog2(CLKS_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_BIT - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   logic             rx_meta_reg;
   logic             rx_sync_reg;
   logic             rx_prev_reg;
   logic [1:0]       rx_state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       bit_idx_reg;
   logic [7:0]       shift_reg;
   logic             byte_ok_reg;
   logic             byte_err_reg;
   logic [7:0]       dado_reg;

   // Synchronize the asynchronous line; preset high so reset never looks like a start bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   // Bit-timing state machine: start recheck at half bit, then mid-bit samples LSB first.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state_reg <= RX_IDLE;
         cnt_reg      <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         byte_ok_reg  <= 1'b0;
         byte_err_reg <= 1'b0;
         dado_reg     <= '0;
      end else begin
         byte_ok_reg  <= 1'b0;
         byte_err_reg <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               cnt_reg <= '0;
               if (rx_prev_reg && !rx_sync_reg) begin
                  rx_state_reg <= RX_START;
               end
            end
            RX_START: begin
               if (cnt_reg == HALF_M1) begin
                  cnt_reg     <= '0;
                  bit_idx_reg <= '0;
                  // A line already back high was a glitch, not a start bit.
                  rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_reg == FULL_M1) begin
                  cnt_reg     <= '0;
                  shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                  bit_idx_reg <= bit_idx_reg + 1'b1;
                  if (bit_idx_reg == 3'd7) begin
                     rx_state_reg <= RX_STOP;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               if (cnt_reg == FULL_M1) begin
                  cnt_reg      <= '0;
                  rx_state_reg <= RX_IDLE;
                  if (rx_sync_reg) begin
                     byte_ok_reg <= 1'b1;
                     dado_reg    <= shift_reg;
                  end else begin
                     byte_err_reg <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         endcase
      end
   end

   assign byte_ok  = byte_ok_reg;
   assign byte_err = byte_err_reg;
   assign dado     = dado_reg;

endmodule

// File: rtl/carregador_senha_serial.sv
// Password loader: receives bytes over UART and writes them one per address
// into the serial password memory, padding with zeros after a line feed.
module carregador_senha_serial
   import polilock_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200,
   parameter int PASS_LEN = 10,
   parameter int ADDR_W   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx,
   input  logic              carregar,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_dado,
   output logic              pronto,
   output logic              erro_quadro,
   output logic [3:0]        db_estado,
   output logic [ADDR_W-1:0] db_contagem
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PASS_LEN - 1);

   logic              rx_byte_ok;
   logic              rx_byte_err;
   logic [7:0]        rx_dado;

   logic [3:0]        state_reg, state_next;
   logic [ADDR_W-1:0] index_reg, index_next;
   logic [7:0]        byte_reg, byte_next;
   logic [ADDR_W-1:0] last_addr_reg;
   logic [7:0]        last_dado_reg;
   logic              wr;
   logic [7:0]        wdata;

   uart_rx_8n1 #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_rx (
      .clock    (clock),
      .reset    (reset),
      .rx       (rx),
      .byte_ok  (rx_byte_ok),
      .byte_err (rx_byte_err),
      .dado     (rx_dado)
   );

   // Write cycles are exactly the GRAVA and PREENCHE states.
   assign wr    = (state_reg == S_GRAVA) || (state_reg == S_PREENCHE);
   assign wdata = (state_reg == S_GRAVA) ? byte_reg : FILL_BYTE;

   // Loader next-state logic: one address per write cycle, never past PASS_LEN.
   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      byte_next  = byte_reg;
      case (state_reg)
         S_OCIOSO, S_FIM, S_ERRO: begin
            if (carregar) begin
               state_next = S_ESPERA;
               index_next = '0;
            end
         end
         S_ESPERA: begin
            if (rx_byte_ok) begin
               byte_next  = rx_dado;
               state_next = (rx_dado == ASCII_LF) ? S_PREENCHE : S_GRAVA;
            end else if (rx_byte_err) begin
               state_next = S_ERRO;
            end
         end
         S_GRAVA: begin
            index_next = index_reg + 1'b1;
            state_next = (index_reg == LAST_IDX) ? S_FIM : S_ESPERA;
         end
         S_PREENCHE: begin
            index_next = index_reg + 1'b1;
            state_next = (index_reg == LAST_IDX) ? S_FIM : S_PREENCHE;
         end
         default: state_next = S_OCIOSO;
      endcase
   end

   // State, index and the held copy of the last write's address/data.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= S_OCIOSO;
         index_reg     <= '0;
         byte_reg      <= '0;
         last_addr_reg <= '0;
         last_dado_reg <= '0;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         byte_reg  <= byte_next;
         if (wr) begin
            last_addr_reg <= index_reg;
            last_dado_reg <= wdata;
         end
      end
   end

   assign mem_we      = wr;
   assign mem_addr    = wr ? index_reg : last_addr_reg;
   assign mem_dado    = wr ? wdata : last_dado_reg;
   assign pronto      = (state_reg == S_FIM);
   assign erro_quadro = (state_reg == S_ERRO);
   assign db_estado   = state_reg;
   assign db_contagem = index_reg;

endmodule
